spi_slave_counter_rx: RTL and testbench
=======================================

Name: spi_slave_counter_rx

Overview:
SPI slave receiver on the display board, directly downstream of the counter master.
- Accepts 2-byte frames over SPI mode 0 (sample on sclk rising edge, MSB first): high byte {2'b00, cnt[13:8]}, then low byte cnt[7:0].
- Reassembles the 14-bit counter value and presents it, with a valid pulse, to the FND display logic.
- Master holds ss permanently low, so byte/frame alignment is recovered by an idle timeout.

Parameters:
TIMEOUT_CYCLES, 10000, clk cycles without an sclk rising edge (mid-frame) before a partial frame is discarded; must exceed the master's inter-byte gap and be far below its 100 ms frame period.

Ports:
clk  input  1  system clock; sclk must be slower than clk/4
reset  input  1  asynchronous, active-high reset
sclk  input  1  SPI clock from master, asynchronous to clk
mosi  input  1  SPI data from master
ss  input  1  slave select, active low
miso  output  1  tied to constant 0
o_counter  output  14  last valid received counter value
o_valid  output  1  one-cycle pulse when o_counter updates
o_err  output  1  one-cycle pulse on framing error
o_frame_cnt  output  8  count of valid frames, wraps 255->0

Behaviour:
- Reset: o_counter=0, o_valid=0, o_err=0, o_frame_cnt=0, miso=0; bit_cnt=0; state=RX_HIGH; timeout counter=0.
- Synchronizer reset values: sclk=0, mosi=0, ss=1.
- sclk, mosi, ss each pass through a 2-FF synchronizer.
- A third sclk register provides rising-edge detect: sclk_s & ~sclk_d gives a 1-cycle edge pulse.
- On the edge pulse, synchronized mosi is shifted into an 8-bit shift register, MSB first, and bit_cnt increments.
- Edge pulses are ignored while synchronized ss is high.
- Synchronized ss high: bit_cnt=0, state=RX_HIGH, timeout counter=0. A partial frame is silently discarded with no o_err.
- Byte complete: the edge pulse with bit_cnt==7 sets bit_cnt=0. The completed byte is {shift[6:0], mosi_s}.
- State machine:
  - RX_HIGH, byte complete: high_reg <= byte; go to RX_LOW.
  - RX_LOW, byte complete, high_reg[7:6]==0: on the next clk, o_counter <= {high_reg[5:0], byte}, o_valid=1 for 1 cycle, o_frame_cnt+1 (wraps). Go to RX_HIGH.
  - RX_LOW, byte complete, high_reg[7:6]!=0: o_err=1 for 1 cycle. o_counter and o_frame_cnt unchanged, no o_valid. Go to RX_HIGH.
- Latency: o_valid is high in the cycle after the edge pulse of the 16th bit, i.e. 3-4 clk after the physical sclk edge.
- Timeout counter:
  - Runs while ss_s is low and (bit_cnt!=0 or state==RX_LOW).
  - Cleared on every edge pulse and while idle (RX_HIGH with bit_cnt==0).
  - On reaching TIMEOUT_CYCLES-1: bit_cnt=0, state=RX_HIGH, counter cleared, o_err pulses for 1 cycle.
- Simultaneous events:
  - Edge pulse and timeout in the same cycle: the edge wins; the bit is accepted and the counter clears.
  - Synchronized ss high in the same cycle as an edge: the edge is ignored.
- No values above 9999 are filtered. Any 14-bit value is passed through unchanged.
- Asynchronous reset mid-frame returns all state to reset values. The next frame is received normally.
- o_counter holds its value between frames. Values are in the clk domain only.

Test Plan:
1. Reset, then frame 0x12,0x34 at sclk=clk/8 -> o_counter=14'h1234; o_valid exactly one 1-cycle pulse; o_frame_cnt=1; o_err never high.
2. Frame 0x27,0x0F -> o_counter=9999 (0x270F). Then frame 0x00,0x00 -> o_counter=0, o_frame_cnt=2.
3. Frame 0xC1,0x00 -> o_err one pulse; o_valid stays low; o_counter keeps its previous value; o_frame_cnt unchanged.
4. Byte 0x12 only, then sclk idle for TIMEOUT_CYCLES+10 -> o_err one pulse about TIMEOUT_CYCLES after the last edge. Then frame 0x00,0x05 -> o_counter=5 (alignment recovered).
5. 3 bits sent, ss pulsed high for 4 clk, then frame 0x01,0x02 -> o_counter=0x0102; no o_err.
6. Reset asserted after 10 bits of a frame -> all outputs 0 immediately. Then 256 valid frames -> o_frame_cnt wraps to 0, last o_counter correct.

Source files
------------

// File: rtl/spi_slave_counter_rx.sv
// SPI mode-0 slave that reassembles 2-byte counter frames {2'b00,cnt[13:8]},{cnt[7:0]}.
// Byte alignment is recovered by an idle timeout because the master holds ss low.
module spi_slave_counter_rx #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  output logic [13:0] o_counter,
  output logic        o_valid,
  output logic        o_err,
  output logic [7:0]  o_frame_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {RX_HIGH, RX_LOW} state_t;

  logic        sclk_q1, sclk_s_q, sclk_d_q;
  logic        mosi_q1, mosi_s_q;
  logic        ss_q1, ss_s_q;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  high_q, high_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [13:0] counter_q, counter_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        sclk_rise;
  logic [7:0]  byte_w;

  // ss resets high so nothing is accepted until the synchronized select is seen low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q1  <= 1'b0;
      sclk_s_q <= 1'b0;
      sclk_d_q <= 1'b0;
      mosi_q1  <= 1'b0;
      mosi_s_q <= 1'b0;
      ss_q1    <= 1'b1;
      ss_s_q   <= 1'b1;
    end else begin
      sclk_q1  <= sclk;
      sclk_s_q <= sclk_q1;
      sclk_d_q <= sclk_s_q;
      mosi_q1  <= mosi;
      mosi_s_q <= mosi_q1;
      ss_q1    <= ss;
      ss_s_q   <= ss_q1;
    end
  end

  assign sclk_rise = sclk_s_q & ~sclk_d_q;
  assign byte_w    = {shift_q[6:0], mosi_s_q};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    high_d      = high_q;
    to_cnt_d    = to_cnt_q;
    counter_d   = counter_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    if (ss_s_q) begin
      bit_cnt_d = 3'd0;
      state_d   = RX_HIGH;
      to_cnt_d  = '0;
    end else if (sclk_rise) begin
      // an edge always wins over a timeout landing in the same cycle
      shift_d  = byte_w;
      to_cnt_d = '0;
      if (bit_cnt_q == 3'd7) begin
        bit_cnt_d = 3'd0;
        case (state_q)
          RX_HIGH: begin
            high_d  = byte_w;
            state_d = RX_LOW;
          end
          default: begin
            if (high_q[7:6] == 2'b00) begin
              counter_d   = {high_q[5:0], byte_w};
              frame_cnt_d = frame_cnt_q + 8'd1;
              valid_d     = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = RX_HIGH;
          end
        endcase
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end else if (bit_cnt_q != 3'd0 || state_q == RX_LOW) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        bit_cnt_d = 3'd0;
        state_d   = RX_HIGH;
        to_cnt_d  = '0;
        err_d     = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RX_HIGH;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      high_q      <= 8'd0;
      to_cnt_q    <= '0;
      counter_q   <= 14'd0;
      frame_cnt_q <= 8'd0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      high_q      <= high_d;
      to_cnt_q    <= to_cnt_d;
      counter_q   <= counter_d;
      frame_cnt_q <= frame_cnt_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign miso        = 1'b0;
  assign o_counter   = counter_q;
  assign o_valid     = valid_q;
  assign o_err       = err_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spi_slave_counter_rx.sv
// Directed bench for spi_slave_counter_rx: frames at sclk = clk/8, error, timeout, ss abort, reset, wrap.
module tb_spi_slave_counter_rx;

  localparam int TO = 10000;

  logic        clk = 1'b0;
  logic        reset, sclk, mosi, ss;
  logic        miso, o_valid, o_err;
  logic [13:0] o_counter;
  logic [7:0]  o_frame_cnt;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_valid = 0, n_err = 0, err_cyc = 0;
  int t_edge = 0;
  int v0, e0, dly;

  always #5 clk = ~clk;

  spi_slave_counter_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss),
    .miso(miso), .o_counter(o_counter), .o_valid(o_valid),
    .o_err(o_err), .o_frame_cnt(o_frame_cnt)
  );

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (o_valid) n_valid <= n_valid + 1;
      if (o_err) begin
        n_err   <= n_err + 1;
        err_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_assert();
    @(negedge clk);
    reset = 1'b1;
    sclk  = 1'b0;
    mosi  = 1'b0;
    ss    = 1'b1;
  endtask

  task automatic reset_release();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    ss = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    mosi = b;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    sclk   = 1'b1;
    t_edge = cyc;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo);
    send_byte(hi);
    repeat (4) @(negedge clk);
    send_byte(lo);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [13:0] val;

    reset_assert();
    #1;
    check("rst_counter", o_counter, 0);
    check("rst_valid", o_valid, 0);
    check("rst_err", o_err, 0);
    check("rst_frame_cnt", o_frame_cnt, 0);
    check("rst_miso", miso, 0);
    reset_release();

    // 1: basic frame
    v0 = n_valid; e0 = n_err;
    send_frame(8'h12, 8'h34);
    check("t1_counter", o_counter, 14'h1234);
    check("t1_valid_pulses", n_valid - v0, 1);
    check("t1_frame_cnt", o_frame_cnt, 1);
    check("t1_no_err", n_err - e0, 0);

    // 2: max display value then zero, from a fresh reset
    reset_assert();
    reset_release();
    send_frame(8'h27, 8'h0F);
    check("t2_counter_9999", o_counter, 14'd9999);
    send_frame(8'h00, 8'h00);
    check("t2_counter_0", o_counter, 0);
    check("t2_frame_cnt", o_frame_cnt, 2);

    // 3: bad high byte
    v0 = n_valid; e0 = n_err;
    send_frame(8'hC1, 8'h00);
    check("t3_err_pulses", n_err - e0, 1);
    check("t3_no_valid", n_valid - v0, 0);
    check("t3_counter_held", o_counter, 0);
    check("t3_frame_cnt_held", o_frame_cnt, 2);

    // 4: half frame then timeout, then alignment recovers
    e0 = n_err;
    send_byte(8'h12);
    repeat (TO + 10) @(negedge clk);
    check("t4_timeout_err", n_err - e0, 1);
    dly = err_cyc - t_edge;
    check("t4_timeout_delay", (dly >= TO && dly <= TO + 5) ? 1 : 0, 1);
    send_frame(8'h00, 8'h05);
    check("t4_counter_5", o_counter, 5);
    check("t4_frame_cnt", o_frame_cnt, 3);

    // 5: ss abort discards partial bits without error
    e0 = n_err;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    ss = 1'b1;
    repeat (4) @(negedge clk);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    send_frame(8'h01, 8'h02);
    check("t5_counter", o_counter, 14'h0102);
    check("t5_no_err", n_err - e0, 0);

    // 6: reset mid-frame, then 256 frames to wrap the frame counter
    send_byte(8'h01);
    send_bit(1'b1);
    send_bit(1'b0);
    reset_assert();
    #1;
    check("t6_rst_counter", o_counter, 0);
    check("t6_rst_frame_cnt", o_frame_cnt, 0);
    check("t6_rst_valid", o_valid, 0);
    check("t6_rst_err", o_err, 0);
    reset_release();
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 256; i++) begin
      val = 14'(i * 53 + 7);
      send_frame({2'b00, val[13:8]}, val[7:0]);
    end
    check("t6_valid_pulses", n_valid - v0, 256);
    check("t6_frame_cnt_wrap", o_frame_cnt, 0);
    check("t6_last_counter", o_counter, 14'h34D2);
    check("t6_no_err", n_err - e0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
